// File: rtl/normalizer_32_if.sv
// Start/Done operand and result bundle for normalizer_32.
interface normalizer_32_if;
  logic        Start;
  logic [31:0] X;
  logic        Signed;
  logic        Busy;
  logic        Done;
  logic [31:0] Norm;
  logic [4:0]  Sa;
  logic        Zero;

  modport master (output Start, X, Signed, input Busy, Done, Norm, Sa, Zero);
  modport slave  (input Start, X, Signed, output Busy, Done, Norm, Sa, Zero);
endinterface

// File: rtl/normalizer_32.sv
// Multi-cycle 32-bit normalizer: one binary stage (16,8,4,2,1) per clock,
// returning the left-justifying shift amount and the normalized word.
module normalizer_32 (
  input  logic            Clk,
  input  logic            Reset,
  normalizer_32_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_w;
  logic        r_sgn;
  logic [4:0]  r_sa;
  logic        r_zero;
  logic [2:0]  r_k;
  logic [31:0] r_norm;
  logic        r_done;
  logic        r_busy;

  logic        w_accept;
  logic        w_pass;
  logic [31:0] w_shifted;

  // Signed mode folds the sign into zeros so both modes share one zero test;
  // the signed test spans n+1 bits so one copy of the sign always survives.
  function automatic logic stage_pass(input logic [31:0] w, input logic sgn,
                                      input logic [2:0] k);
    logic [31:0] t;
    int          n;
    int          lim;
    n   = 1 << k;
    t   = w ^ {32{sgn & w[31]}};
    lim = sgn ? (31 - n) : (32 - n);
    return (t >> lim) == 32'd0;
  endfunction

  assign w_accept  = bus.Start && (r_state != S_SHIFT);
  assign w_pass    = stage_pass(r_w, r_sgn, r_k);
  assign w_shifted = r_w << (6'd1 << r_k);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.Start) w_next = S_SHIFT;
      S_SHIFT: if (r_k == 3'd0) w_next = S_DONE;
      S_DONE:  w_next = bus.Start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control: state and registered status flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Datapath: operand latch, per-stage shift, result capture
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_w    <= 32'd0;
      r_sgn  <= 1'b0;
      r_sa   <= 5'd0;
      r_zero <= 1'b0;
      r_k    <= 3'd0;
      r_norm <= 32'd0;
    end else if (w_accept) begin
      r_w    <= bus.X;
      r_sgn  <= bus.Signed;
      r_sa   <= 5'd0;
      r_zero <= (bus.X == 32'd0);
      r_k    <= 3'd4;
      r_norm <= 32'd0;
    end else if (r_state == S_SHIFT) begin
      if (w_pass) begin
        r_w       <= w_shifted;
        r_sa[r_k] <= 1'b1;
      end
      if (r_k == 3'd0) r_norm <= w_pass ? w_shifted : r_w;
      else             r_k    <= r_k - 3'd1;
    end
  end

  assign bus.Busy = r_busy;
  assign bus.Done = r_done;
  assign bus.Norm = r_norm;
  assign bus.Sa   = r_sa;
  assign bus.Zero = r_zero;

endmodule

// File: tb/tb_normalizer_32.sv
// Scoreboard bench for normalizer_32: directed boundary cases, held-Start,
// mid-operation reset and randomized operands against a counting model.
module tb_normalizer_32;

  typedef struct {
    logic [31:0] x;
    logic        s;
    logic [31:0] norm;
    logic [4:0]  sa;
    logic        zero;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q[$];

  normalizer_32_if bus ();

  normalizer_32 dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Count leading zeros, or leading copies of the sign beyond the sign itself.
  function automatic exp_t model(input logic [31:0] x, input logic s, input int c0);
    exp_t e;
    int   c = 0;
    if (!s) begin
      for (int i = 31; i >= 0; i--) begin
        if (x[i] == 1'b0) c++;
        else break;
      end
    end else begin
      for (int i = 30; i >= 0; i--) begin
        if (x[i] == x[31]) c++;
        else break;
      end
    end
    if (c > 31) c = 31;
    e.x    = x;
    e.s    = s;
    e.sa   = 5'(c);
    e.norm = x << c;
    e.zero = (x == 32'd0);
    e.cyc  = c0 + 5;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.Done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        logic [31:0] back;
        e = q.pop_front();
        chk("sa", {27'd0, bus.Sa}, {27'd0, e.sa});
        chk("norm", bus.Norm, e.norm);
        chk("zero", {31'd0, bus.Zero}, {31'd0, e.zero});
        chk("latency", cyc, e.cyc);
        if (!e.zero) begin
          back = e.s ? 32'($signed(bus.Norm) >>> bus.Sa) : (bus.Norm >> bus.Sa);
          chk("invariant", back, e.x);
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] x, input logic s);
    int g = 0;
    while (bus.Busy && !bus.Done && g < 50) begin
      @(negedge clk);
      g++;
    end
    bus.Start  = 1'b1;
    bus.X      = x;
    bus.Signed = s;
    @(negedge clk);
    q.push_back(model(x, s, cyc));
    bus.Start  = 1'b0;
    bus.X      = $urandom;
    bus.Signed = 1'($urandom_range(0, 1));
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (bus.Busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  logic [31:0] dx[7]  = '{32'h00F00000, 32'h80000000, 32'hFFFFFF80, 32'h00000003,
                          32'hFFFFFFFF, 32'h00000000, 32'h00000000};
  logic        ds[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int cnt;
    int g;
    logic [31:0] x;
    logic [31:0] xb;
    bus.Start  = 1'b0;
    bus.X      = 32'd0;
    bus.Signed = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_done", {31'd0, bus.Done}, 32'd0);
    chk("rst_norm", bus.Norm, 32'd0);
    chk("rst_sa", {27'd0, bus.Sa}, 32'd0);
    chk("rst_zero", {31'd0, bus.Zero}, 32'd0);

    // First operation with Busy duration measured
    bus.Start = 1'b1;
    bus.X     = 32'h00000001;
    bus.Signed = 1'b0;
    @(negedge clk);
    q.push_back(model(32'h00000001, 1'b0, cyc));
    bus.Start = 1'b0;
    cnt = 0;
    g = 0;
    while (bus.Busy && g < 20) begin
      cnt++;
      @(negedge clk);
      g++;
    end
    chk("busy_cycles", cnt, 6);

    for (int i = 0; i < 7; i++) run_op(dx[i], ds[i]);
    wait_idle();

    // Start held high; operand changes during the operation must be ignored
    xb = 32'h0000F00D;
    bus.Start  = 1'b1;
    bus.X      = 32'h00012345;
    bus.Signed = 1'b0;
    @(negedge clk);
    q.push_back(model(32'h00012345, 1'b0, cyc));
    bus.X = 32'hDEADBEEF;
    bus.Signed = 1'b1;
    repeat (3) @(negedge clk);
    bus.X = xb;
    bus.Signed = 1'b1;
    repeat (3) @(negedge clk);
    chk("b2b_busy", {31'd0, bus.Busy}, 32'd1);
    chk("b2b_done", {31'd0, bus.Done}, 32'd0);
    q.push_back(model(xb, 1'b1, cyc));
    bus.Start = 1'b0;
    repeat (5) @(negedge clk);
    wait_idle();

    // Reset lands on the edge that would run stage k=2
    bus.Start  = 1'b1;
    bus.X      = 32'h00000010;
    bus.Signed = 1'b0;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.Done}, 32'd0);
    chk("mid_rst_norm", bus.Norm, 32'd0);
    chk("mid_rst_sa", {27'd0, bus.Sa}, 32'd0);
    chk("mid_rst_zero", {31'd0, bus.Zero}, 32'd0);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 10000; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = ~x;
      run_op(x, 1'($urandom_range(0, 1)));
    end
    wait_idle();

    g = 0;
    while (q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("queue_drained", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
